// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampled UART receive front end.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VERIFY,
        RECEIVE
    } state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;

    // Start bit + data + optional parity + stop bit(s).
    function automatic int frame_bits(int data_width, int parity_enabled, int stop_bits);
        return 1 + data_width + parity_enabled + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_frame_tracker_if.sv
// Tick/line inputs and frame-tracking outputs of the Rx front end.
// The slave side is the tracker; the master side is the synchroniser/consumer.
interface uart_rx_frame_tracker_if #(
    parameter int IDX_W = 4
);
    logic             baud_tick;
    logic             serial_in_synced;
    logic             start_detected;
    logic             false_start;
    logic             frame_active;
    logic             sample_strobe;
    logic             sampled_bit;
    logic [IDX_W-1:0] bit_index;
    logic             frame_done;
    logic             framing_error;

    modport master (
        output baud_tick, serial_in_synced,
        input  start_detected, false_start, frame_active, sample_strobe,
               sampled_bit, bit_index, frame_done, framing_error
    );

    modport slave (
        input  baud_tick, serial_in_synced,
        output start_detected, false_start, frame_active, sample_strobe,
               sampled_bit, bit_index, frame_done, framing_error
    );
endinterface

// File: rtl/uart_rx_bit_sampler.sv
// Tick counter and mid-bit decision for the Rx front end.
// Optional macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote over three consecutive
// ticks around mid-bit, with the decision moved one tick later.
module uart_rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   baud_tick,
    input  logic   line,
    input  state_t state,
    output logic   decide,
    output logic   bit_val
);
    localparam int CW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int DECIDE_AT = OVERSAMPLE / 2 + 1;
`else
    localparam int DECIDE_AT = OVERSAMPLE / 2;
`endif

    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = tick_cnt + 1'b1;

    // Decision tick: mid-bit of the start bit in VERIFY, counter wrap in RECEIVE.
    always_comb begin
        decide = 1'b0;
        if (baud_tick) begin
            case (state)
                VERIFY:  decide = (cnt_inc == CW'(DECIDE_AT));
                RECEIVE: decide = (tick_cnt == CW'(OVERSAMPLE - 1));
                default: decide = 1'b0;
            endcase
        end
    end

    // Counter restarts at every decision so the next one lands one bit period later.
    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (baud_tick)
            tick_cnt <= (state == IDLE || decide) ? '0 : cnt_inc;
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist;

    // Keep the two previous tick samples; with the current one they form the vote window.
    always_ff @(posedge clk) begin
        if (reset)
            hist <= 2'b11;
        else if (baud_tick)
            hist <= {hist[0], line};
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & line) | (hist[0] & line);
`else
    assign bit_val = line;
`endif

endmodule

// File: rtl/uart_rx_frame_tracker.sv
// Oversampled UART Rx frame tracker: start-bit validation, per-bit sample
// strobes with index, and stop-bit check. All outputs are registered.
// Optional macro UART_RX_MAJORITY_VOTE_EN (see uart_rx_bit_sampler).
module uart_rx_frame_tracker
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PARITY_ENABLED = 1,
    parameter int STOP_BITS      = 1,
    parameter int OVERSAMPLE     = DEFAULT_OVERSAMPLE
) (
    input logic clk,
    input logic reset,
    uart_rx_frame_tracker_if.slave bus
);
    localparam int FRAME_BITS = frame_bits(DATA_WIDTH, PARITY_ENABLED, STOP_BITS);
    localparam int IDX_W      = $clog2(FRAME_BITS);
    localparam int STOP_FIRST = FRAME_BITS - STOP_BITS;

    state_t           state, state_nxt;
    logic             prev_line, fall_edge, decide, bit_val;
    logic             start_detected, false_start, frame_active, sample_strobe;
    logic             sampled_bit, frame_done, framing_error, stop_err;
    logic [IDX_W-1:0] bit_index;
    logic             start_nxt, false_nxt, active_nxt, strobe_nxt, bit_nxt;
    logic             done_nxt, ferr_nxt, serr_nxt;
    logic [IDX_W-1:0] idx_nxt;

    assign fall_edge = bus.baud_tick && prev_line && !bus.serial_in_synced;

    uart_rx_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk     (clk),
        .reset   (reset),
        .baud_tick(bus.baud_tick),
        .line    (bus.serial_in_synced),
        .state   (state),
        .decide  (decide),
        .bit_val (bit_val)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and next output values; pulses default low, levels hold.
    always_comb begin
        state_nxt  = state;
        start_nxt  = 1'b0;
        false_nxt  = 1'b0;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        bit_nxt    = sampled_bit;
        idx_nxt    = bit_index;
        active_nxt = frame_active;
        ferr_nxt   = framing_error;
        serr_nxt   = stop_err;
        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (fall_edge) begin
                    state_nxt  = VERIFY;
                    active_nxt = 1'b1;
                end
            end
            VERIFY: begin
                if (decide) begin
                    if (!bit_val) begin
                        state_nxt  = RECEIVE;
                        start_nxt  = 1'b1;
                        strobe_nxt = 1'b1;
                        bit_nxt    = 1'b0;
                        idx_nxt    = '0;
                        serr_nxt   = 1'b0;
                    end else begin
                        state_nxt  = IDLE;
                        false_nxt  = 1'b1;
                        active_nxt = 1'b0;
                    end
                end
            end
            RECEIVE: begin
                if (decide) begin
                    strobe_nxt = 1'b1;
                    bit_nxt    = bit_val;
                    idx_nxt    = bit_index + 1'b1;
                    if (idx_nxt >= IDX_W'(STOP_FIRST) && !bit_val)
                        serr_nxt = 1'b1;
                    if (bit_index == IDX_W'(FRAME_BITS - 2)) begin
                        state_nxt  = IDLE;
                        done_nxt   = 1'b1;
                        ferr_nxt   = serr_nxt;
                        active_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers and the edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_line      <= 1'b1;
            start_detected <= 1'b0;
            false_start    <= 1'b0;
            frame_active   <= 1'b0;
            sample_strobe  <= 1'b0;
            sampled_bit    <= 1'b0;
            bit_index      <= '0;
            frame_done     <= 1'b0;
            framing_error  <= 1'b0;
            stop_err       <= 1'b0;
        end else begin
            if (bus.baud_tick) prev_line <= bus.serial_in_synced;
            start_detected <= start_nxt;
            false_start    <= false_nxt;
            frame_active   <= active_nxt;
            sample_strobe  <= strobe_nxt;
            sampled_bit    <= bit_nxt;
            bit_index      <= idx_nxt;
            frame_done     <= done_nxt;
            framing_error  <= ferr_nxt;
            stop_err       <= serr_nxt;
        end
    end

    assign bus.start_detected = start_detected;
    assign bus.false_start    = false_start;
    assign bus.frame_active   = frame_active;
    assign bus.sample_strobe  = sample_strobe;
    assign bus.sampled_bit    = sampled_bit;
    assign bus.bit_index      = bit_index;
    assign bus.frame_done     = frame_done;
    assign bus.framing_error  = framing_error;

endmodule

// File: tb/tb_uart_rx_frame_tracker.sv
// Self-checking bench: per-tick line waveforms are built in an array, a
// tick-domain reference model derives the expected events, and the DUT
// outputs are compared after every baud tick and on the idle cycles between.
module tb_uart_rx_frame_tracker;
    localparam int OS = 16;
    localparam int FB = 11;
    localparam int SB = 1;
    localparam int N  = 4096;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam bit VOTE = 1'b1;
`else
    localparam bit VOTE = 1'b0;
`endif
    localparam int D = OS / 2 + (VOTE ? 1 : 0);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_frame_tracker_if #(.IDX_W(4)) bus ();

    uart_rx_frame_tracker #(
        .DATA_WIDTH(8), .PARITY_ENABLED(1), .STOP_BITS(SB), .OVERSAMPLE(OS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    bit wave [N];
    bit m_start [N], m_false [N], m_strobe [N], m_bit [N], m_done [N];
    bit m_ferr [N], m_act [N], m_ferr_at [N];
    int m_idx [N];
    int checks = 0, errors = 0;
    int strobes_seen, done_seen, starts_seen;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit vote_at(int p);
        if (VOTE)
            return (wave[p-2] & wave[p-1]) | (wave[p-2] & wave[p]) | (wave[p-1] & wave[p]);
        return wave[p];
    endfunction

    task automatic init_wave();
        for (int i = 0; i < N; i++) wave[i] = 1'b1;
    endtask

    // Even parity, LSB-first data, stop bit forced low when stop_ok is 0.
    task automatic put_frame(input int pos, input logic [7:0] data, input bit stop_ok);
        bit v;
        for (int b = 0; b < FB; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = data[b-1];
            else if (b == 9) v = ^data;
            else             v = stop_ok;
            for (int k = 0; k < OS; k++) wave[pos + OS*b + k] = v;
        end
    endtask

    // Reference: walk the tick waveform, find start edges while idle and
    // place decisions D ticks after an edge, then one every OS ticks.
    task automatic model(input int n);
        int t, e, s, last, p;
        bit prev, err, v, cur;
        for (int i = 0; i < n; i++) begin
            m_start[i] = 0; m_false[i] = 0; m_strobe[i] = 0; m_bit[i] = 0;
            m_done[i] = 0; m_act[i] = 0; m_ferr_at[i] = 0; m_idx[i] = 0;
        end
        t = 0; prev = 1'b1;
        while (t < n) begin
            if (prev && !wave[t]) begin
                e = t; s = e + D;
                if (s >= n) begin
                    for (int i = e; i < n; i++) m_act[i] = 1;
                    t = n;
                end else if (vote_at(s)) begin
                    m_false[s] = 1;
                    for (int i = e; i < s; i++) m_act[i] = 1;
                    prev = wave[s]; t = s + 1;
                end else begin
                    m_start[s] = 1; err = 0; last = -1;
                    for (int b = 0; b < FB; b++) begin
                        p = s + OS*b;
                        if (p >= n) break;
                        v = vote_at(p);
                        m_strobe[p] = 1; m_bit[p] = v; m_idx[p] = b;
                        if (b >= FB - SB && !v) err = 1;
                        if (b == FB - 1) begin m_done[p] = 1; m_ferr_at[p] = err; last = p; end
                    end
                    if (last < 0) begin
                        for (int i = e; i < n; i++) m_act[i] = 1;
                        t = n;
                    end else begin
                        for (int i = e; i < last; i++) m_act[i] = 1;
                        prev = wave[last]; t = last + 1;
                    end
                end
            end else begin
                prev = wave[t]; t++;
            end
        end
        cur = 0;
        for (int i = 0; i < n; i++) begin
            if (m_done[i]) cur = m_ferr_at[i];
            m_ferr[i] = cur;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.baud_tick = 1'b0; bus.serial_in_synced = 1'b1;
        @(posedge clk); #1;
        chk("reset_outs", {bus.start_detected, bus.false_start, bus.frame_active,
            bus.sample_strobe, bus.sampled_bit, bus.bit_index, bus.frame_done,
            bus.framing_error}, 16'h0);
        reset = 1'b0;
        strobes_seen = 0; done_seen = 0; starts_seen = 0;
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) begin
            bus.baud_tick = 1'b1; bus.serial_in_synced = wave[t];
            @(posedge clk); #1;
            chk("start_detected", bus.start_detected, m_start[t]);
            chk("false_start",    bus.false_start,    m_false[t]);
            chk("sample_strobe",  bus.sample_strobe,  m_strobe[t]);
            chk("frame_done",     bus.frame_done,     m_done[t]);
            chk("frame_active",   bus.frame_active,   m_act[t]);
            chk("framing_error",  bus.framing_error,  m_ferr[t]);
            if (m_strobe[t]) begin
                chk("sampled_bit", bus.sampled_bit, m_bit[t]);
                chk("bit_index",   bus.bit_index,   m_idx[t][3:0]);
            end
            strobes_seen += int'(bus.sample_strobe);
            done_seen    += int'(bus.frame_done);
            starts_seen  += int'(bus.start_detected);
            bus.baud_tick = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk("no_tick_pulse", {bus.start_detected, bus.false_start,
                    bus.sample_strobe, bus.frame_done}, 16'h0);
            end
        end
    endtask

    initial begin
        int pos, len;
        reset = 1'b1; bus.baud_tick = 1'b0; bus.serial_in_synced = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Idle line.
        do_reset(); init_wave(); model(200); run(200);
        chk("idle_strobes", 16'(strobes_seen), 16'd0);

        // Short low glitch -> false start.
        do_reset(); init_wave();
        for (int i = 10; i < 14; i++) wave[i] = 1'b0;
        model(60); run(60);
        chk("glitch_starts", 16'(starts_seen), 16'd0);

        // Clean 0xA5 frame.
        do_reset(); init_wave(); put_frame(5, 8'hA5, 1'b1); model(200); run(200);
        chk("a5_strobes", 16'(strobes_seen), 16'd11);
        chk("a5_done", 16'(done_seen), 16'd1);

        // Bad stop, break held low, then a clean frame.
        do_reset(); init_wave(); put_frame(5, 8'hA5, 1'b0);
        for (int i = 5 + OS*FB; i < 5 + OS*FB + 50; i++) wave[i] = 1'b0;
        put_frame(5 + OS*FB + 70, 8'hA5, 1'b1);
        model(5 + 2*OS*FB + 90); run(5 + 2*OS*FB + 90);
        chk("break_starts", 16'(starts_seen), 16'd2);

        // Back-to-back frames.
        do_reset(); init_wave(); put_frame(5, 8'h5A, 1'b1); put_frame(5 + OS*FB, 8'hC3, 1'b1);
        model(5 + 2*OS*FB + 20); run(5 + 2*OS*FB + 20);
        chk("b2b_done", 16'(done_seen), 16'd2);

        // Reset mid-frame at bit_index 4, then a clean 0x3C frame.
        do_reset(); init_wave(); put_frame(5, 8'hA5, 1'b1); model(5 + D + 4*OS + 1);
        run(5 + D + 4*OS + 1);
        chk("abort_no_done", 16'(done_seen), 16'd0);
        do_reset(); init_wave(); put_frame(3, 8'h3C, 1'b1); model(200); run(200);
        chk("3c_done", 16'(done_seen), 16'd1);

        // One-tick low glitch at mid-bit of data bit 0 (a 1).
        do_reset(); init_wave(); put_frame(5, 8'hFF, 1'b1); wave[5 + OS + OS/2] = 1'b0;
        model(200); run(200);

        // Randomised frames with false starts and in-frame glitches.
        for (int r = 0; r < 4; r++) begin
            do_reset(); init_wave(); pos = 0;
            for (int f = 0; f < 3; f++) begin
                pos += $urandom_range(2, 30);
                if ($urandom_range(0, 2) == 0) begin
                    len = $urandom_range(1, 3);
                    for (int i = 0; i < len; i++) wave[pos + i] = 1'b0;
                    pos += len + 12;
                end
                put_frame(pos, 8'($urandom), $urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1)
                    wave[pos + OS*$urandom_range(1, 8) + $urandom_range(0, OS-1)] ^= 1'b1;
                pos += OS*FB;
            end
            model(pos + 20); run(pos + 20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
